// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline stage with skid buffer and operand forwarding
//
// Purpose: registers a decoded instruction bundle between decode and execute.
//   The stage holds one main entry and one skid entry, so in_ready depends only
//   on registered state. Operands are resolved against the MEM and WB
//   forwarding buses at capture time. While an entry is held, it keeps being
//   re-resolved so that a stalled operand picks up later writebacks.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             synchronous kill of both entries and same-cycle input
//   in_valid/in_ready decode-side handshake; in_* bundle fields
//   fwd_mem_*, fwd_wb_* forwarding sources (valid, destination, data)
//   out_valid/out_ready execute-side handshake
//   out_rs1, out_rs2, out_alu_ctrl, out_rd_addr  registered ALU inputs
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_rs1_data,
  input  logic [DATA_WIDTH-1:0]     in_rs2_data,
  input  logic [DATA_WIDTH-1:0]     in_imm,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd_addr,
  input  logic [3:0]                in_alu_ctrl,
  input  logic                      in_use_imm,
  input  logic                      fwd_mem_valid,
  input  logic                      fwd_wb_valid,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_mem_rd,
  input  logic [REG_ADDR_WIDTH-1:0] fwd_wb_rd,
  input  logic [DATA_WIDTH-1:0]     fwd_mem_data,
  input  logic [DATA_WIDTH-1:0]     fwd_wb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_rs1,
  output logic [DATA_WIDTH-1:0]     out_rs2,
  output logic [3:0]                out_alu_ctrl,
  output logic [REG_ADDR_WIDTH-1:0] out_rd_addr
);

  localparam logic [3:0] ALU_ZERO = 4'ha;

  typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

  // Source indices and use_imm travel with the entry so it can be re-resolved.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     a;
    logic [DATA_WIDTH-1:0]     b;
    logic [REG_ADDR_WIDTH-1:0] ra;
    logic [REG_ADDR_WIDTH-1:0] rb;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [3:0]                ctrl;
    logic                      imm;
  } entry_t;

  state_t state, state_next;
  entry_t main_q, skid_q, main_d, skid_d;
  entry_t in_entry, main_ref, skid_ref, idle_entry;
  logic   accept, release_now;

  // MEM has priority over WB; x0 is hardwired and never forwarded.
  function automatic logic [DATA_WIDTH-1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] addr,
    input logic [DATA_WIDTH-1:0]     dflt
  );
    if (addr != '0 && fwd_mem_valid && fwd_mem_rd == addr) return fwd_mem_data;
    if (addr != '0 && fwd_wb_valid && fwd_wb_rd == addr)   return fwd_wb_data;
    return dflt;
  endfunction

  // Re-resolve a held entry; an unmatched operand keeps its current value.
  function automatic entry_t refresh(input entry_t e);
    entry_t r;
    r   = e;
    r.a = fwd_sel(e.ra, e.a);
    if (!e.imm) r.b = fwd_sel(e.rb, e.b);
    return r;
  endfunction

  always_comb begin
    idle_entry      = '0;
    idle_entry.ctrl = ALU_ZERO;

    in_entry      = '0;
    in_entry.ra   = in_rs1_addr;
    in_entry.rb   = in_rs2_addr;
    in_entry.rd   = in_rd_addr;
    in_entry.ctrl = in_alu_ctrl;
    in_entry.imm  = in_use_imm;
    in_entry.a    = fwd_sel(in_rs1_addr, in_rs1_data);
    in_entry.b    = in_use_imm ? in_imm : fwd_sel(in_rs2_addr, in_rs2_data);

    main_ref = refresh(main_q);
    skid_ref = refresh(skid_q);
  end

  assign in_ready    = (state != SKID);
  assign out_valid   = (state != EMPTY);
  assign accept      = in_valid && in_ready;
  assign release_now = out_valid && out_ready;

  always_comb begin
    state_next = state;
    main_d     = main_q;
    skid_d     = skid_q;
    if (flush) begin
      state_next = EMPTY;
      main_d     = idle_entry;
      skid_d     = idle_entry;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_d     = in_entry;
            state_next = FULL;
          end
        end
        FULL: begin
          main_d = main_ref;
          case ({accept, release_now})
            2'b11:   main_d = in_entry;
            2'b01:   state_next = EMPTY;
            2'b10: begin
              skid_d     = in_entry;
              state_next = SKID;
            end
            default: ;
          endcase
        end
        SKID: begin
          main_d = main_ref;
          skid_d = skid_ref;
          if (release_now) begin
            main_d     = skid_ref;
            state_next = FULL;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= EMPTY;
      main_q      <= '0;
      main_q.ctrl <= ALU_ZERO;
      skid_q      <= '0;
      skid_q.ctrl <= ALU_ZERO;
    end else begin
      state  <= state_next;
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign out_rs1      = main_q.a;
  assign out_rs2      = main_q.b;
  assign out_alu_ctrl = main_q.ctrl;
  assign out_rd_addr  = main_q.rd;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage against a queue model
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_use_imm;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [3:0]  in_alu_ctrl;
  logic        fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid, out_ready;
  logic [31:0] out_rs1, out_rs2;
  logic [3:0]  out_alu_ctrl;
  logic [4:0]  out_rd_addr;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  ra, rb, rd;
    logic [3:0]  ctrl;
    bit          imm;
  } ent_t;
  ent_t q[$];

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alu_ctrl(in_alu_ctrl), .in_use_imm(in_use_imm),
    .fwd_mem_valid(fwd_mem_valid), .fwd_wb_valid(fwd_wb_valid),
    .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_alu_ctrl(out_alu_ctrl), .out_rd_addr(out_rd_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Forwarding rule from the register-file point of view.
  function automatic logic [31:0] pick(input logic [4:0] addr, input logic [31:0] dflt);
    if (addr == 0) return dflt;
    if (fwd_mem_valid && fwd_mem_rd == addr) return fwd_mem_data;
    if (fwd_wb_valid && fwd_wb_rd == addr) return fwd_wb_data;
    return dflt;
  endfunction

  // One clock edge of the reference: a FIFO of at most two bundles.
  task automatic model_step();
    ent_t e;
    bit   rel, acc;
    if (rst || flush) begin
      q.delete();
      return;
    end
    rel = (q.size() > 0) && out_ready;
    acc = in_valid && (q.size() < 2);
    for (int i = 0; i < q.size(); i++) begin
      q[i].a = pick(q[i].ra, q[i].a);
      if (!q[i].imm) q[i].b = pick(q[i].rb, q[i].b);
    end
    if (rel) void'(q.pop_front());
    if (acc) begin
      e.ra = in_rs1_addr; e.rb = in_rs2_addr; e.rd = in_rd_addr;
      e.ctrl = in_alu_ctrl; e.imm = in_use_imm;
      e.a = pick(in_rs1_addr, in_rs1_data);
      e.b = in_use_imm ? in_imm : pick(in_rs2_addr, in_rs2_data);
      q.push_back(e);
    end
  endtask

  task automatic compare();
    check("in_ready", in_ready, q.size() < 2);
    check("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("out_rs1", out_rs1, q[0].a);
      check("out_rs2", out_rs2, q[0].b);
      check("out_alu_ctrl", out_alu_ctrl, q[0].ctrl);
      check("out_rd_addr", out_rd_addr, q[0].rd);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic check_idle(input string tag, input bit with_rd);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_rs1"}, out_rs1, 32'h0);
    check({tag, "_rs2"}, out_rs2, 32'h0);
    check({tag, "_ctrl"}, out_alu_ctrl, 4'ha);
    if (with_rd) check({tag, "_rd"}, out_rd_addr, 5'h0);
  endtask

  task automatic push_in(input logic [4:0] r1a, input logic [31:0] r1d,
                         input logic [4:0] r2a, input logic [31:0] r2d,
                         input bit uimm, input logic [31:0] imd,
                         input logic [4:0] rd, input logic [3:0] ctrl);
    in_valid = 1'b1;
    in_rs1_addr = r1a; in_rs1_data = r1d;
    in_rs2_addr = r2a; in_rs2_data = r2d;
    in_use_imm = uimm; in_imm = imd;
    in_rd_addr = rd; in_alu_ctrl = ctrl;
  endtask

  task automatic fwd_off();
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0;
    fwd_mem_rd = 0; fwd_wb_rd = 0; fwd_mem_data = 0; fwd_wb_data = 0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    push_in(0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    fwd_off();
    #1;
    check_idle("reset", 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    compare();

    // Streaming at full rate.
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_in(5'd1, i, 5'd2, 32'h100 + i, 0, 0, 5'd3, 4'h0);
      cyc();
      check("stream_rs1", out_rs1, i);
      check("stream_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    cyc();

    // Backpressure into the skid entry, then in-order drain.
    out_ready = 1'b0;
    push_in(5'd1, 32'h10, 5'd2, 32'h1, 0, 0, 5'd4, 4'h1);
    cyc();
    push_in(5'd1, 32'h20, 5'd2, 32'h2, 0, 0, 5'd5, 4'h2);
    cyc();
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_head", out_rs1, 32'h10);
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    check("bp_second", out_rs1, 32'h20);
    check("bp_second_valid", out_valid, 1'b1);
    cyc();
    check("bp_drained", out_valid, 1'b0);

    // Forwarding priority and x0.
    fwd_mem_valid = 1; fwd_mem_rd = 5; fwd_mem_data = 32'hAA;
    fwd_wb_valid = 1; fwd_wb_rd = 5; fwd_wb_data = 32'hBB;
    push_in(5'd5, 32'h11, 5'd0, 32'h3, 0, 0, 5'd6, 4'h3);
    cyc();
    check("fwd_mem_wins", out_rs1, 32'hAA);
    fwd_mem_rd = 0; fwd_wb_rd = 0;
    push_in(5'd0, 32'h22, 5'd0, 32'h4, 0, 0, 5'd6, 4'h3);
    cyc();
    check("fwd_x0", out_rs1, 32'h22);
    fwd_mem_valid = 0; fwd_wb_rd = 6;
    push_in(5'd6, 32'h33, 5'd6, 32'h5, 1, 32'h77, 5'd6, 4'h4);
    cyc();
    check("fwd_wb", out_rs1, 32'hBB);
    check("imm_no_fwd", out_rs2, 32'h77);
    fwd_off();
    in_valid = 1'b0;
    cyc();

    // Stalled operand tracks a later writeback.
    out_ready = 1'b0;
    push_in(5'd1, 32'h9, 5'd7, 32'h33, 0, 0, 5'd8, 4'h5);
    cyc();
    check("stall_before", out_rs2, 32'h33);
    in_valid = 1'b0;
    fwd_wb_valid = 1; fwd_wb_rd = 7; fwd_wb_data = 32'h55;
    cyc();
    check("stall_refresh", out_rs2, 32'h55);
    check("stall_valid", out_valid, 1'b1);
    fwd_off();
    out_ready = 1'b1;
    cyc();

    // Flush while in SKID with a same-cycle input.
    out_ready = 1'b0;
    push_in(5'd1, 32'hA1, 5'd2, 32'hA2, 0, 0, 5'd9, 4'h6);
    cyc();
    push_in(5'd1, 32'hB1, 5'd2, 32'hB2, 0, 0, 5'd10, 4'h7);
    cyc();
    check("pre_flush_skid", in_ready, 1'b0);
    flush = 1'b1;
    push_in(5'd1, 32'hC1, 5'd2, 32'hC2, 0, 0, 5'd11, 4'h8);
    cyc();
    check_idle("flush", 0);
    flush = 1'b0; in_valid = 1'b0;

    // Randomized traffic with frequent forwarding hits.
    for (int n = 0; n < 500; n++) begin
      push_in($urandom_range(0, 3), $urandom, $urandom_range(0, 3), $urandom,
              $urandom_range(0, 1), $urandom, $urandom_range(0, 31), $urandom_range(0, 10));
      in_valid = $urandom_range(0, 1);
      out_ready = $urandom_range(0, 2) != 0;
      flush = ($urandom_range(0, 40) == 0);
      fwd_mem_valid = $urandom_range(0, 1); fwd_mem_rd = $urandom_range(0, 3);
      fwd_mem_data = $urandom;
      fwd_wb_valid = $urandom_range(0, 1); fwd_wb_rd = $urandom_range(0, 3);
      fwd_wb_data = $urandom;
      cyc();
    end
    flush = 1'b0;
    fwd_off();

    // Asynchronous reset in the middle of a cycle while FULL.
    out_ready = 1'b0;
    push_in(5'd1, 32'hD1, 5'd2, 32'hD2, 0, 0, 5'd12, 4'h9);
    cyc();
    in_valid = 1'b0;
    cyc();
    check("pre_reset_full", out_valid, 1'b1);
    @(posedge clk);
    model_step();
    #2 rst = 1'b1;
    #1;
    check_idle("async_reset", 1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    push_in(5'd1, 32'hE1, 5'd2, 32'hE2, 0, 0, 5'd13, 4'h1);
    cyc();
    check("post_reset_first", out_rs1, 32'hE1);
    in_valid = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
